passthrough_rr_sched: RTL and testbench
=======================================

// Module: passthrough_rr_sched
// PURPOSE
//  Shares one Passthrough datapath (in_data -> out_data, 8-bit, combinational) between NUM_REQ requesters.
//  - Round-robin arbitration.
//  - Drives the datapath input and registers the datapath output into a one-entry valid/ready output stage
//    tagged with the source id.
//  - Sits between requester FIFOs and the shared Passthrough instance.
// PARAMETERS
//  NUM_REQ  4   number of requesters, 2..8
//  DATA_W   8   datapath width; must match the Passthrough port width
//  CNT_W    16  width of the transfer counter
// PORTS
//  CLK        in   1                clock, rising edge
//  RST_N      in   1                asynchronous, active-low reset
//  req_valid  in   NUM_REQ          per-requester data valid
//  req_data   in   NUM_REQ*DATA_W   requester i occupies bits [i*DATA_W +: DATA_W]
//  req_ready  out  NUM_REQ          one-hot accept, combinational
//  dp_in      out  DATA_W           to Passthrough in_data
//  dp_out     in   DATA_W           from Passthrough out_data
//  out_valid  out  1                registered result valid
//  out_data   out  DATA_W           registered result
//  out_src    out  clog2(NUM_REQ)   index of the requester that produced out_data
//  out_ready  in   1                downstream accept
//  xfer_cnt   out  CNT_W            accepted transfers, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (RST_N=0, async):
//   - out_valid=0, out_data=0, out_src=0, xfer_cnt=0.
//   - last_grant=NUM_REQ-1, so requester 0 has first priority; state=IDLE.
//   - req_ready=0 while reset is asserted.
//  can_accept = !out_valid | out_ready.
//  Grant selection (combinational):
//   - Pick the first i with req_valid[i]=1, scanning last_grant+1, +2, ... modulo NUM_REQ.
//   - grant_vld = can_accept & |req_valid.
//  req_ready[i] = grant_vld & (i==pick); at most one bit is set per cycle.
//  dp_in = req_data[pick] when grant_vld, else 0. dp_in is never X.
//  States:
//   - IDLE: out_valid=0. On grant_vld -> FULL.
//   - FULL: out_valid=1.
//     - out_ready & grant_vld -> stay FULL, entry replaced.
//     - out_ready & !grant_vld -> IDLE.
//     - !out_ready -> hold out_data and out_src stable, no grant.
//  On each edge with grant_vld:
//   - out_data<=dp_out, out_src<=pick, last_grant<=pick.
//   - xfer_cnt<=xfer_cnt+1, wrapping from 2^CNT_W-1 to 0.
//  Latency: req accept to out_valid = 1 cycle. Throughput: 1 transfer/cycle while out_ready=1.
//  Boundary conditions:
//   - No valid requesters: no grant; last_grant unchanged.
//   - A requester may drop req_valid while not granted; it loses nothing.
//   - Output pop and new accept in the same cycle are both honoured.
//   - Reset mid-transfer discards the held entry; no partial output appears after reset release.
//   - last_grant is updated only on an actual grant.
// STRUCTURE
//  - passthrough_defs.vh: DATA_W default, state encodings (IDLE=1'b0, FULL=1'b1), clog2 macro.
//  - Sub-module rr_pick (combinational): inputs req_valid and last_grant; outputs pick and any.
//    Reused by later arbiters.
//  - Top file holds the FSM, output register, counter and dp_in mux.
// TESTING
//  1. Single stream: req0 sends 0x00,0x01,... every cycle, out_ready=1
//     -> out_data follows dp_out one cycle later, out_src=0, xfer_cnt increments each cycle.
//  2. All four requesters valid continuously, out_ready=1
//     -> grant order 0,1,2,3,0,1; one req_ready bit per cycle.
//  3. After reset, req2 and req3 valid -> first grant 2, next 3.
//     Then only req2 valid after grant 3 -> req2 granted.
//  4. Backpressure: out_ready=0 for 5 cycles with an entry held
//     -> out_data/out_src stable, req_ready=0.
//     When out_ready=1 -> pop and new accept in the same cycle.
//  5. RST_N pulsed low mid-stream, asynchronous to CLK -> immediate out_valid=0 and xfer_cnt=0.
//     First post-reset grant goes to the lowest valid index.
//  6. CNT_W=4: 17 transfers -> xfer_cnt reads 1 (wrap).
//     Idle cycles leave xfer_cnt and dp_in (=0) unchanged.

Source files
------------

// File: rtl/passthrough_rr_sched_pkg.sv
// Shared types and helpers for the round-robin scheduler that fronts a
// combinational passthrough datapath.
package passthrough_rr_sched_pkg;

  localparam int DATA_W_DEF = 8;

  // Output stage occupancy.
  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/passthrough_rr_sched_rr_pick.sv
// Combinational round-robin picker: finds the first valid requester after
// last_grant, wrapping modulo NUM_REQ. Kept standalone for reuse.
module passthrough_rr_sched_rr_pick
  import passthrough_rr_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   pick,
  output logic               any
);

  // Scan last_grant+1, +2, ... and keep the first hit.
  always_comb begin : scan
    logic [IDX_W-1:0] idx;
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    pick = '0;
    any  = 1'b0;
    idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!any && req_valid[idx]) begin
        pick = idx;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/passthrough_rr_sched.sv
// Round-robin scheduler sharing one combinational passthrough datapath among
// NUM_REQ requesters, with a one-entry valid/ready output register tagged by
// source index and a wrapping count of accepted transfers.
module passthrough_rr_sched
  import passthrough_rr_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CNT_W   = 16
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           dp_in,
  input  logic [DATA_W-1:0]           dp_out,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic [idx_w(NUM_REQ)-1:0]   out_src,
  input  logic                        out_ready,
  output logic [CNT_W-1:0]            xfer_cnt
);

  localparam int IDX_W = idx_w(NUM_REQ);

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] pick;
  logic             any;
  logic             can_accept;
  logic             grant_vld;

  passthrough_rr_sched_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .pick       (pick),
    .any        (any)
  );

  // Grant only when the output slot is free or draining, and never in reset.
  assign out_valid  = (state_q == FULL);
  assign can_accept = !out_valid || out_ready;
  assign grant_vld  = RST_N && can_accept && any;

  // One-hot accept and datapath input mux; dp_in is zero when nothing is granted.
  always_comb begin
    req_ready = '0;
    dp_in     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_vld && (pick == IDX_W'(i))) begin
        req_ready[i] = 1'b1;
        dp_in        = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // State register for the output stage.
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: fill on a grant, empty when popped with nothing new accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld) state_d = FULL;
      FULL:    if (out_ready && !grant_vld) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture datapath result, source tag, priority pointer and count on each grant.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_data   <= '0;
      out_src    <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      xfer_cnt   <= '0;
    end else if (grant_vld) begin
      out_data   <= dp_out;
      out_src    <= pick;
      last_grant <= pick;
      xfer_cnt   <= xfer_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_passthrough_rr_sched.sv
// Directed bench for passthrough_rr_sched: a reference model tracks the
// round-robin pointer, output occupancy and counter, and a scoreboard queue
// carries each accepted entry until the DUT presents it.
module tb_passthrough_rr_sched;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 4;
  localparam int IDX_W   = 2;

  logic                      CLK   = 1'b0;
  logic                      RST_N = 1'b1;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         dp_in;
  logic [DATA_W-1:0]         dp_out;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic [IDX_W-1:0]          out_src;
  logic                      out_ready;
  logic [CNT_W-1:0]          xfer_cnt;

  always #5 CLK = ~CLK;

  // Shared datapath stand-in: a pure combinational passthrough.
  assign dp_out = dp_in;

  passthrough_rr_sched #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .CNT_W   (CNT_W)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .dp_in     (dp_in),
    .dp_out    (dp_out),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt)
  );

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  src;
  } entry_t;

  int          checks = 0;
  int          errors = 0;
  entry_t      sb[$];
  logic        m_valid;
  logic [CNT_W-1:0] m_cnt;
  int          m_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference round robin: walk forward from the last grant.
  function automatic int model_pick(input logic [NUM_REQ-1:0] v, input int last);
    int i;
    i = last;
    repeat (NUM_REQ) begin
      i = (i == NUM_REQ - 1) ? 0 : i + 1;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_cnt   = '0;
    m_last  = NUM_REQ - 1;
    sb.delete();
  endtask

  // One clock of stimulus: drive after a falling edge, check mid-cycle, update model.
  task automatic cycle(input logic [NUM_REQ-1:0] v, input logic [31:0] d,
                       input logic ordy, input string tag);
    int          p;
    logic        gv;
    logic [7:0]  sel;
    entry_t      e;
    req_valid = v;
    req_data  = d;
    out_ready = ordy;
    #1;
    p   = model_pick(v, m_last);
    gv  = (!m_valid || ordy) && (p >= 0);
    sel = (p >= 0) ? d[p*8 +: 8] : 8'h00;
    check({tag, ":req_ready"}, 32'(req_ready), gv ? (32'd1 << p) : 32'd0);
    check({tag, ":dp_in"},     32'(dp_in),     gv ? 32'(sel) : 32'd0);
    check({tag, ":out_valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, ":xfer_cnt"},  32'(xfer_cnt),  32'(m_cnt));
    if (m_valid) begin
      check({tag, ":sb_depth"}, 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
        e = ordy ? sb.pop_front() : sb[0];
        check({tag, ":out_data"}, 32'(out_data), 32'(e.data));
        check({tag, ":out_src"},  32'(out_src),  32'(e.src));
      end
    end
    if (gv) begin
      sb.push_back('{data: sel, src: 2'(p)});
      m_last  = p;
      m_cnt   = m_cnt + 1'b1;
      m_valid = 1'b1;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    @(negedge CLK);
  endtask

  // Synchronous-looking reset pulse between falling edges, with in-reset checks.
  task automatic pulse_reset(input string tag);
    RST_N = 1'b0;
    #1;
    check({tag, ":rst_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ":rst_out_data"},  32'(out_data),  32'd0);
    check({tag, ":rst_out_src"},   32'(out_src),   32'd0);
    check({tag, ":rst_xfer_cnt"},  32'(xfer_cnt),  32'd0);
    check({tag, ":rst_req_ready"}, 32'(req_ready), 32'd0);
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    model_reset();

    // Reset with all requesters asking: nothing may be accepted.
    #1;
    req_valid = 4'hF;
    req_data  = 32'h44332211;
    @(negedge CLK);
    pulse_reset("reset");

    // Single stream from requester 0, one item per cycle.
    for (int i = 0; i < 8; i++) cycle(4'b0001, 32'(i), 1'b1, "single");
    cycle(4'b0000, 32'h0, 1'b1, "single_drain");

    // All requesters valid: rotation 0,1,2,3,0,...
    for (int i = 0; i < 8; i++)
      cycle(4'b1111, 32'hD3C2B1A0 + 32'(i) * 32'h01010101, 1'b1, "all");
    cycle(4'b0000, 32'h0, 1'b1, "all_drain");

    // After reset: requesters 2 and 3, then only 2; then a drop while waiting.
    pulse_reset("reset2");
    cycle(4'b1100, 32'h4D3C2B1A, 1'b1, "pair");
    cycle(4'b1100, 32'h4E3D2C1B, 1'b1, "pair");
    cycle(4'b0100, 32'h4F3E2D1C, 1'b1, "only2");
    cycle(4'b0110, 32'h77665544, 1'b1, "drop_a");
    cycle(4'b1000, 32'h88776655, 1'b1, "drop_b");
    cycle(4'b0000, 32'h0, 1'b1, "drop_drain");

    // Backpressure: hold for five cycles, then pop and accept together.
    cycle(4'b0001, 32'h000000A5, 1'b1, "bp_load");
    repeat (5) cycle(4'b1111, 32'h44332211, 1'b0, "bp_hold");
    cycle(4'b1111, 32'h44332211, 1'b1, "bp_release");
    cycle(4'b0000, 32'h0, 1'b1, "bp_drain");
    cycle(4'b0000, 32'h0, 1'b1, "bp_idle");

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 3; i++)
      cycle(4'b1111, 32'h5A4B3C2D + 32'(i), 1'b1, "mid");
    #3;
    RST_N = 1'b0;
    #1;
    check("async:out_valid", 32'(out_valid), 32'd0);
    check("async:xfer_cnt",  32'(xfer_cnt),  32'd0);
    check("async:out_data",  32'(out_data),  32'd0);
    check("async:req_ready", 32'(req_ready), 32'd0);
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    cycle(4'b1010, 32'hAABBCCDD, 1'b1, "post_rst");
    cycle(4'b0000, 32'h0, 1'b1, "post_rst_drain");

    // Counter wrap: 17 transfers on a 4-bit counter leave it at 1.
    pulse_reset("reset3");
    for (int i = 0; i < 17; i++) cycle(4'b0001, 32'(8'hE0 + i), 1'b1, "wrap");
    check("wrap:xfer_cnt_17", 32'(xfer_cnt), 32'd1);
    repeat (3) cycle(4'b0000, 32'hFFFFFFFF, 1'b1, "wrap_idle");
    check("wrap:xfer_cnt_idle", 32'(xfer_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
